multi_cycle_alu: RTL and testbench

//  Parametrised successor to the TinyALU single-cycle datapath. Adds a WIDTH-generic

---
 rtl/alu_pkg.sv | 24 ++
 rtl/multi_cycle_alu_if.sv | 18 +
 rtl/shift_add_mul.sv | 71 +++++++
 rtl/multi_cycle_alu.sv | 100 ++++++++++
 tb/tb_multi_cycle_alu.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state types for the multi-cycle ALU and its command interface.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_XOR  = 3'b011,
        OP_MUL  = 3'b100,
        OP_RSV5 = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    function automatic logic is_reserved(input op_e op);
        return op inside {OP_RSV5, OP_RSV6, OP_RSV7};
    endfunction

endpackage

// File: rtl/multi_cycle_alu_if.sv
// Start/done command interface between a requester (master) and the ALU (slave).
interface multi_cycle_alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic               start;
    op_e                op;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic               err;
    logic [2*WIDTH-1:0] result;

    modport master (output start, op, A, B, input busy, done, err, result);
    modport slave  (input start, op, A, B, output busy, done, err, result);
endinterface

// File: rtl/shift_add_mul.sv
// Unsigned shift-add multiplier: one partial product per clock, WIDTH clocks per product.
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             last;

    assign last = run_q && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + (PW'(mcand_q) << cnt_q);
            end
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    // valid/product are combinational so the final sum lands in the result register on the last step edge
    assign busy_o    = run_q;
    assign valid_o   = last;
    assign product_o = acc_d;

endmodule

// File: rtl/multi_cycle_alu.sv
// Command decode, single-cycle datapath and result/done/err registers around the multiplier.
module multi_cycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multi_cycle_alu_if.slave        bus
);
    localparam int PW = 2 * WIDTH;

    state_e        state_q, state_d;
    logic [PW-1:0] result_q, result_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          mul_load;
    logic          mul_busy;
    logic          mul_valid;
    logic [PW-1:0] mul_product;

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (mul_load),
        .a_i       (bus.A),
        .b_i       (bus.B),
        .busy_o    (mul_busy),
        .valid_o   (mul_valid),
        .product_o (mul_product)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mul_load = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (is_reserved(bus.op)) begin
                        result_d = '0;
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        case (bus.op)
                            OP_ADD: begin
                                result_d = PW'(bus.A) + PW'(bus.B);
                                done_d   = 1'b1;
                            end
                            OP_AND: begin
                                result_d = PW'(bus.A & bus.B);
                                done_d   = 1'b1;
                            end
                            OP_XOR: begin
                                result_d = PW'(bus.A ^ bus.B);
                                done_d   = 1'b1;
                            end
                            OP_MUL: begin
                                mul_load = 1'b1;
                                state_d  = S_MUL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            // start is deliberately not looked at here: commands during a multiply are dropped
            S_MUL: begin
                if (mul_valid) begin
                    result_d = mul_product;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy   = mul_busy;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Self-checking bench for multi_cycle_alu at WIDTH=8 and WIDTH=4.
module tb_multi_cycle_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst8_n;
    logic rst4_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    multi_cycle_alu_if #(.WIDTH(8)) if8 ();
    multi_cycle_alu_if #(.WIDTH(4)) if4 ();

    multi_cycle_alu #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(if8));
    multi_cycle_alu #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(if4));

    typedef struct {
        op_e         op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_res;
        logic        exp_err;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] res_of(input bit sel);
        return sel ? 16'(if4.result) : if8.result;
    endfunction
    function automatic logic done_of(input bit sel);
        return sel ? if4.done : if8.done;
    endfunction
    function automatic logic err_of(input bit sel);
        return sel ? if4.err : if8.err;
    endfunction
    function automatic logic busy_of(input bit sel);
        return sel ? if4.busy : if8.busy;
    endfunction

    task automatic drive(input bit sel, input logic st, input op_e op, input logic [7:0] a, input logic [7:0] b);
        if (sel) begin
            if4.start = st; if4.op = op; if4.A = a[3:0]; if4.B = b[3:0];
        end else begin
            if8.start = st; if8.op = op; if8.A = a;      if8.B = b;
        end
    endtask

    // Behavioural reference: plain arithmetic on the masked operands
    function automatic logic [15:0] model(input int w, input op_e op, input logic [7:0] a, input logic [7:0] b);
        int m;
        int aa;
        int bb;
        m  = (1 << w) - 1;
        aa = int'(a) & m;
        bb = int'(b) & m;
        case (op)
            OP_ADD:  return 16'(aa + bb);
            OP_AND:  return 16'(aa & bb);
            OP_XOR:  return 16'(aa ^ bb);
            OP_MUL:  return 16'(aa * bb);
            default: return 16'h0;
        endcase
    endfunction

    // Issue one command and wait (bounded) for its done; lat counts negedges after the start edge.
    task automatic run_cmd(input bit sel, input op_e op, input logic [7:0] a, input logic [7:0] b, input bit poke,
                           output logic [15:0] r, output logic e, output int lat, output int busy_n,
                           output logic trail);
        drive(sel, 1'b1, op, a, b);
        lat    = 0;
        busy_n = 0;
        r      = 'x;
        e      = 'x;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (busy_of(sel)) busy_n++;
            if (done_of(sel)) begin
                lat = c;
                r   = res_of(sel);
                e   = err_of(sel);
                break;
            end
            if (poke && busy_of(sel))
                drive(sel, 1'($urandom_range(0, 1)), op_e'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            else
                drive(sel, 1'b0, op, a, b);
        end
        if (lat == 0) lat = 99;
        drive(sel, 1'b0, OP_NOP, 8'h00, 8'h00);
        @(negedge clk);
        trail = done_of(sel) | err_of(sel);
    endtask

    initial begin
        logic [15:0] r;
        logic        e;
        logic        trail;
        int          lat;
        int          busy_n;
        int          dcount;
        int          w;
        logic        held;
        logic        early;
        logic [15:0] last8;
        logic [15:0] last4;
        logic [15:0] exp;
        logic        nop_ok;
        op_e         op;
        logic [7:0]  a;
        logic [7:0]  b;
        bit          sel;

        tbl[0]  = '{OP_ADD,  8'hFF, 8'h01, 16'h0100, 1'b0};
        tbl[1]  = '{OP_ADD,  8'hFF, 8'hFF, 16'h01FE, 1'b0};
        tbl[2]  = '{OP_ADD,  8'h00, 8'h00, 16'h0000, 1'b0};
        tbl[3]  = '{OP_XOR,  8'hA5, 8'h0F, 16'h00AA, 1'b0};
        tbl[4]  = '{OP_AND,  8'hF0, 8'h3C, 16'h0030, 1'b0};
        tbl[5]  = '{OP_MUL,  8'hFF, 8'hFF, 16'hFE01, 1'b0};
        tbl[6]  = '{OP_MUL,  8'h03, 8'h05, 16'h000F, 1'b0};
        tbl[7]  = '{OP_MUL,  8'h00, 8'hFF, 16'h0000, 1'b0};
        tbl[8]  = '{OP_MUL,  8'h80, 8'h02, 16'h0100, 1'b0};
        tbl[9]  = '{OP_RSV5, 8'h12, 8'h34, 16'h0000, 1'b1};
        tbl[10] = '{OP_RSV7, 8'hFF, 8'hFF, 16'h0000, 1'b1};
        tbl[11] = '{OP_MUL,  8'h01, 8'h80, 16'h0080, 1'b0};

        drive(0, 1'b0, OP_NOP, 8'h00, 8'h00);
        drive(1, 1'b0, OP_NOP, 8'h00, 8'h00);
        rst8_n = 1'b0;
        rst4_n = 1'b0;
        repeat (2) @(negedge clk);
        rst8_n = 1'b1;
        rst4_n = 1'b1;
        @(negedge clk);
        check("reset_result", 32'(if8.result), 32'h0);
        check("reset_done",   32'(if8.done),   32'h0);
        check("reset_busy",   32'(if8.busy),   32'h0);
        check("reset_err",    32'(if8.err),    32'h0);

        // Table-driven directed vectors
        foreach (tbl[i]) begin
            run_cmd(0, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, r, e, lat, busy_n, trail);
            check($sformatf("tbl%0d_result", i), 32'(r), 32'(tbl[i].exp_res));
            check($sformatf("tbl%0d_err", i),    32'(e), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_latency", i), 32'(lat), (tbl[i].op == OP_MUL) ? 32'd9 : 32'd1);
            check($sformatf("tbl%0d_busy_cycles", i), 32'(busy_n), (tbl[i].op == OP_MUL) ? 32'd8 : 32'd0);
            check($sformatf("tbl%0d_single_pulse", i), 32'(trail), 32'h0);
        end

        // Back-to-back single-cycle commands
        drive(0, 1'b1, OP_XOR, 8'hA5, 8'h0F);
        @(negedge clk);
        check("b2b_xor_done",   32'(if8.done),   32'h1);
        check("b2b_xor_result", 32'(if8.result), 32'h00AA);
        drive(0, 1'b1, OP_AND, 8'hF0, 8'h3C);
        @(negedge clk);
        check("b2b_and_done",   32'(if8.done),   32'h1);
        check("b2b_and_result", 32'(if8.result), 32'h0030);
        drive(0, 1'b0, OP_NOP, 8'h00, 8'h00);
        @(negedge clk);
        check("b2b_idle_done",  32'(if8.done),   32'h0);

        // MUL FF*FF: old result held, busy for 8 cycles, done on the 8th edge after start
        drive(0, 1'b1, OP_MUL, 8'hFF, 8'hFF);
        held = 1'b1; early = 1'b0; busy_n = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (if8.result !== 16'h0030) held = 1'b0;
            if (if8.busy) busy_n++;
            if (if8.done) early = 1'b1;
            drive(0, 1'b0, OP_MUL, 8'h00, 8'h00);
        end
        @(negedge clk);
        check("mul_ff_done",    32'(if8.done),   32'h1);
        check("mul_ff_result",  32'(if8.result), 32'hFE01);
        check("mul_ff_busy_lo", 32'(if8.busy),   32'h0);
        check("mul_ff_held",    32'(held),       32'h1);
        check("mul_ff_busy_n",  32'(busy_n),     32'd8);
        check("mul_ff_early",   32'(early),      32'h0);

        // ADD during busy is ignored; ADD in the done cycle is accepted
        drive(0, 1'b1, OP_MUL, 8'h03, 8'h05);
        dcount = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (if8.done) dcount++;
            drive(0, c == 3, OP_ADD, 8'h01, 8'h01);
        end
        @(negedge clk);
        check("ign_mul_done",   32'(if8.done),   32'h1);
        check("ign_mul_result", 32'(if8.result), 32'h000F);
        check("ign_no_early",   32'(dcount),     32'h0);
        check("ign_no_err",     32'(if8.err),    32'h0);
        drive(0, 1'b1, OP_ADD, 8'h01, 8'h01);
        @(negedge clk);
        check("done_cycle_add_done",   32'(if8.done),   32'h1);
        check("done_cycle_add_result", 32'(if8.result), 32'h0002);
        drive(0, 1'b0, OP_NOP, 8'h00, 8'h00);

        // Reserved opcode then NOP
        drive(0, 1'b1, OP_RSV5, 8'h12, 8'h34);
        @(negedge clk);
        check("rsv_done",   32'(if8.done),   32'h1);
        check("rsv_err",    32'(if8.err),    32'h1);
        check("rsv_result", 32'(if8.result), 32'h0);
        drive(0, 1'b1, OP_ADD, 8'h20, 8'h22);
        @(negedge clk);
        check("rsv_err_pulse", 32'(if8.err),    32'h0);
        check("post_add",      32'(if8.result), 32'h0042);
        drive(0, 1'b1, OP_NOP, 8'h77, 8'h88);
        nop_ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (if8.done || if8.err || if8.result !== 16'h0042) nop_ok = 1'b0;
            drive(0, 1'b0, OP_NOP, 8'h00, 8'h00);
        end
        check("nop_quiet", 32'(nop_ok), 32'h1);

        // Reset in the middle of a multiply
        drive(0, 1'b1, OP_MUL, 8'hFF, 8'hFF);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            drive(0, 1'b0, OP_NOP, 8'h00, 8'h00);
        end
        rst8_n = 1'b0;
        #1;
        check("midrst_result", 32'(if8.result), 32'h0);
        check("midrst_busy",   32'(if8.busy),   32'h0);
        @(negedge clk);
        rst8_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (if8.done || if8.busy) dcount++;
        end
        check("midrst_no_done", 32'(dcount), 32'h0);

        // WIDTH=4 multiply
        run_cmd(1, OP_MUL, 8'h0F, 8'h0F, 1'b0, r, e, lat, busy_n, trail);
        check("w4_mul_result",  32'(r),      32'h00E1);
        check("w4_mul_latency", 32'(lat),    32'd5);
        check("w4_mul_busy_n",  32'(busy_n), 32'd4);

        // Randomized commands against the reference model, with ignored pokes while busy
        last8 = if8.result;
        last4 = 16'(if4.result);
        for (int i = 0; i < 160; i++) begin
            sel = (i % 4) == 3;
            w   = sel ? 4 : 8;
            op  = op_e'($urandom_range(0, 7));
            a   = 8'($urandom);
            b   = 8'($urandom);
            if (op == OP_NOP) begin
                drive(sel, 1'b1, op, a, b);
                nop_ok = 1'b1;
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    if (done_of(sel) || res_of(sel) !== (sel ? last4 : last8)) nop_ok = 1'b0;
                    drive(sel, 1'b0, OP_NOP, 8'h00, 8'h00);
                end
                check($sformatf("rnd%0d_nop", i), 32'(nop_ok), 32'h1);
            end else begin
                run_cmd(sel, op, a, b, 1'($urandom_range(0, 1)), r, e, lat, busy_n, trail);
                exp = model(w, op, a, b);
                check($sformatf("rnd%0d_result", i), 32'(r), 32'(exp));
                check($sformatf("rnd%0d_err", i),    32'(e), 32'(is_reserved(op)));
                check($sformatf("rnd%0d_latency", i), 32'(lat), (op == OP_MUL) ? 32'(w + 1) : 32'd1);
                if (sel) last4 = exp; else last8 = exp;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
